// File: rtl/fetch0_predecode.sv
// First fetch stage: pre-decodes the instruction queue's head pair for JAL and
// backward branches, registers the pair toward decode, and issues predicted redirects.
module fetch0_predecode #(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iq0_vld_i,
  input  logic [PC_WIDTH-1:0]   iq0_pc_i,
  input  logic [INST_WIDTH-1:0] iq0_inst_i,
  input  logic                  iq1_vld_i,
  input  logic [PC_WIDTH-1:0]   iq1_pc_i,
  input  logic [INST_WIDTH-1:0] iq1_inst_i,
  output logic                  stall_iq_o,
  output logic                  flush_iq_o,
  output logic                  redirect_vld_o,
  output logic [PC_WIDTH-1:0]   redirect_pc_o,
  output logic                  f0_vld0_o,
  output logic [PC_WIDTH-1:0]   f0_pc0_o,
  output logic [INST_WIDTH-1:0] f0_inst0_o,
  output logic                  f0_vld1_o,
  output logic [PC_WIDTH-1:0]   f0_pc1_o,
  output logic [INST_WIDTH-1:0] f0_inst1_o,
  output logic                  f0_pred_taken_o,
  input  logic                  stall_i,
  input  logic                  flush_i
);

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic                taken;
    logic [PC_WIDTH-1:0] target;
  } pred_t;

  state_e state, state_nxt;

  // JAL is always taken; conditional branches are taken only when the offset is
  // negative (inst[31] is the immediate sign bit), i.e. backward-taken.
  function automatic pred_t predecode(input logic                  vld,
                                      input logic [PC_WIDTH-1:0]   pc,
                                      input logic [INST_WIDTH-1:0] inst);
    pred_t               p;
    logic [PC_WIDTH-1:0] imm_j;
    logic [PC_WIDTH-1:0] imm_b;
    logic                is_jal;
    logic                is_br;
    imm_j  = {{(PC_WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_b  = {{(PC_WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    is_jal = (inst[6:0] == OPC_JAL);
    is_br  = (inst[6:0] == OPC_BRANCH);
    p.taken  = vld && (is_jal || (is_br && inst[31]));
    p.target = pc + (is_jal ? imm_j : imm_b);
    return p;
  endfunction

  pred_t pred0, pred1;
  logic  pred_any;
  logic  accept;
  logic  hold;

  assign pred0    = predecode(iq0_vld_i, iq0_pc_i, iq0_inst_i);
  assign pred1    = predecode(iq1_vld_i, iq1_pc_i, iq1_inst_i);
  assign pred_any = pred0.taken || pred1.taken;

  // accept mirrors the queue's own dequeue condition so both sides agree on
  // which pair left the queue.
  assign hold       = f0_vld0_o && stall_i;
  assign stall_iq_o = hold || (state == REDIR);
  assign accept     = (state == RUN) && iq0_vld_i && iq1_vld_i && !stall_iq_o && !flush_i;

  assign redirect_vld_o = (state == REDIR) && !flush_i;
  assign flush_iq_o     = (state == REDIR) && !flush_i;

  // NOTE: every variable written in always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = RUN;
    case (state)
      RUN:     if (accept && pred_any) state_nxt = REDIR;
      REDIR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (flush_i) state_nxt = RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_o <= '0;
    end else if (accept && pred_any) begin
      redirect_pc_o <= pred0.taken ? pred0.target : pred1.target;
    end
  end

  // Valids and prediction flag: flush beats everything, then a new pair, then a
  // downstream hold; otherwise the pair has been consumed and the register empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0_vld0_o       <= 1'b0;
      f0_vld1_o       <= 1'b0;
      f0_pred_taken_o <= 1'b0;
    end else if (flush_i) begin
      f0_vld0_o       <= 1'b0;
      f0_vld1_o       <= 1'b0;
      f0_pred_taken_o <= 1'b0;
    end else if (accept) begin
      f0_vld0_o       <= 1'b1;
      f0_vld1_o       <= !pred0.taken;
      f0_pred_taken_o <= pred_any;
    end else if (!hold) begin
      f0_vld0_o       <= 1'b0;
      f0_vld1_o       <= 1'b0;
      f0_pred_taken_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0_pc0_o   <= '0;
      f0_inst0_o <= '0;
      f0_pc1_o   <= '0;
      f0_inst1_o <= '0;
    end else if (accept) begin
      f0_pc0_o   <= iq0_pc_i;
      f0_inst0_o <= iq0_inst_i;
      f0_pc1_o   <= iq1_pc_i;
      f0_inst1_o <= iq1_inst_i;
    end
  end

endmodule

// File: tb/tb_fetch0_predecode.sv
// Directed bench for fetch0_predecode: vector table for pre-decode/priority plus
// hand-written sequences for stall, flush and asynchronous reset corners.
module tb_fetch0_predecode;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] JAL_P16 = 32'h0100_006F;
  localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;
  localparam logic [31:0] BEQ_M4  = 32'hFE00_0EE3;
  localparam logic [31:0] BEQ_P8  = 32'h0000_0463;
  localparam logic [31:0] JALR    = 32'h0000_00E7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iq0_vld, iq1_vld;
  logic [63:0] iq0_pc, iq1_pc;
  logic [31:0] iq0_inst, iq1_inst;
  logic        stall_iq, flush_iq, redirect_vld;
  logic [63:0] redirect_pc;
  logic        f0_vld0, f0_vld1, f0_pred_taken;
  logic [63:0] f0_pc0, f0_pc1;
  logic [31:0] f0_inst0, f0_inst1;
  logic        stall, flush;

  int errors = 0;
  int checks = 0;

  fetch0_predecode dut (
    .clk(clk), .rst_n(rst_n),
    .iq0_vld_i(iq0_vld), .iq0_pc_i(iq0_pc), .iq0_inst_i(iq0_inst),
    .iq1_vld_i(iq1_vld), .iq1_pc_i(iq1_pc), .iq1_inst_i(iq1_inst),
    .stall_iq_o(stall_iq), .flush_iq_o(flush_iq),
    .redirect_vld_o(redirect_vld), .redirect_pc_o(redirect_pc),
    .f0_vld0_o(f0_vld0), .f0_pc0_o(f0_pc0), .f0_inst0_o(f0_inst0),
    .f0_vld1_o(f0_vld1), .f0_pc1_o(f0_pc1), .f0_inst1_o(f0_inst1),
    .f0_pred_taken_o(f0_pred_taken),
    .stall_i(stall), .flush_i(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_pair(input logic v0, input logic [63:0] p0, input logic [31:0] i0,
                            input logic v1, input logic [63:0] p1, input logic [31:0] i1);
    iq0_vld = v0; iq0_pc = p0; iq0_inst = i0;
    iq1_vld = v1; iq1_pc = p1; iq1_inst = i1;
  endtask

  task automatic idle_iq();
    drive_pair(1'b0, 64'h0, NOP, 1'b0, 64'h0, NOP);
  endtask

  typedef struct {
    string       name;
    logic        v0;
    logic [63:0] p0;
    logic [31:0] i0;
    logic        v1;
    logic [63:0] p1;
    logic [31:0] i1;
    logic        e_vld0;
    logic        e_vld1;
    logic        e_taken;
    logic [63:0] e_target;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"straight",   1, 64'h1000, NOP,     1, 64'h1004, NOP,     1, 1, 0, 64'h0};
    vecs[1] = '{"jal_s0",     1, 64'h2000, JAL_P16, 1, 64'h2004, NOP,     1, 0, 1, 64'h2010};
    vecs[2] = '{"bwd_br_s1",  1, 64'h3000, NOP,     1, 64'h3004, BEQ_M4,  1, 1, 1, 64'h3000};
    vecs[3] = '{"fwd_br_s1",  1, 64'h3000, NOP,     1, 64'h3004, BEQ_P8,  1, 1, 0, 64'h0};
    vecs[4] = '{"partial",    1, 64'h3800, JAL_P16, 0, 64'h3804, NOP,     0, 0, 0, 64'h0};
    vecs[5] = '{"jalr_s0",    1, 64'h3900, JALR,    1, 64'h3904, NOP,     1, 1, 0, 64'h0};
    vecs[6] = '{"both_taken", 1, 64'h4000, BEQ_M4,  1, 64'h4004, JAL_M8,  1, 0, 1, 64'h3FFC};
    vecs[7] = '{"jal_neg_s1", 1, 64'h5000, BEQ_P8,  1, 64'h5004, JAL_M8,  1, 1, 1, 64'h4FFC};
    vecs[8] = '{"wrap",       1, 64'h0,    JAL_M8,  1, 64'h4,    NOP,     1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8};

    idle_iq();
    stall = 0; flush = 0;
    #12;
    check("rst_vld0", f0_vld0, 0);
    check("rst_stall_iq", stall_iq, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    rst_n = 1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive_pair(vecs[k].v0, vecs[k].p0, vecs[k].i0, vecs[k].v1, vecs[k].p1, vecs[k].i1);
      @(posedge clk); #1;
      check({vecs[k].name, ".vld0"}, f0_vld0, vecs[k].e_vld0);
      check({vecs[k].name, ".vld1"}, f0_vld1, vecs[k].e_vld1);
      check({vecs[k].name, ".taken"}, f0_pred_taken, vecs[k].e_taken);
      check({vecs[k].name, ".redir_vld"}, redirect_vld, vecs[k].e_taken);
      check({vecs[k].name, ".flush_iq"}, flush_iq, vecs[k].e_taken);
      check({vecs[k].name, ".stall_iq"}, stall_iq, vecs[k].e_taken);
      if (vecs[k].e_vld0) check({vecs[k].name, ".pc0"}, f0_pc0, vecs[k].p0);
      if (vecs[k].e_vld1) check({vecs[k].name, ".pc1"}, f0_pc1, vecs[k].p1);
      if (vecs[k].e_taken) check({vecs[k].name, ".target"}, redirect_pc, vecs[k].e_target);
      @(negedge clk);
      idle_iq();
      @(posedge clk); #1;
      check({vecs[k].name, ".after_redir"}, redirect_vld, 0);
      check({vecs[k].name, ".after_stall_iq"}, stall_iq, 0);
      check({vecs[k].name, ".after_vld0"}, f0_vld0, 0);
    end

    // Downstream stall holds the pair for 3 cycles; the next pair goes in when it drops.
    @(negedge clk);
    drive_pair(1, 64'h6000, NOP, 1, 64'h6004, 32'h0010_0093);
    @(posedge clk); #1;
    check("stall.load_pc0", f0_pc0, 64'h6000);
    @(negedge clk);
    stall = 1;
    drive_pair(1, 64'h6100, NOP, 1, 64'h6104, NOP);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("stall.stall_iq", stall_iq, 1);
      check("stall.vld0", f0_vld0, 1);
      check("stall.pc0", f0_pc0, 64'h6000);
      check("stall.inst1", f0_inst1, 32'h0010_0093);
    end
    @(negedge clk);
    stall = 0;
    #1;
    check("stall.release_stall_iq", stall_iq, 0);
    @(posedge clk); #1;
    check("stall.next_pc0", f0_pc0, 64'h6100);
    check("stall.next_vld1", f0_vld1, 1);

    // flush_i during REDIR suppresses the redirect and empties the output register.
    @(negedge clk);
    drive_pair(1, 64'h7000, JAL_P16, 1, 64'h7004, NOP);
    @(posedge clk); #1;
    check("fredir.in_redir", redirect_vld, 1);
    @(negedge clk);
    idle_iq();
    flush = 1;
    #1;
    check("fredir.redir_vld", redirect_vld, 0);
    check("fredir.flush_iq", flush_iq, 0);
    check("fredir.stall_iq", stall_iq, 1);
    @(posedge clk); #1;
    check("fredir.vld0", f0_vld0, 0);
    check("fredir.taken", f0_pred_taken, 0);
    check("fredir.run_stall_iq", stall_iq, 0);

    // A pair presented while flush_i is high is not accepted.
    @(negedge clk);
    drive_pair(1, 64'h7100, NOP, 1, 64'h7104, NOP);
    @(posedge clk); #1;
    check("flush_block.vld0", f0_vld0, 0);
    @(negedge clk);
    flush = 0;
    @(posedge clk); #1;
    check("flush_after.vld0", f0_vld0, 1);
    check("flush_after.pc0", f0_pc0, 64'h7100);

    // REDIR with downstream stall: redirect still fires, pair stays held.
    @(negedge clk);
    drive_pair(1, 64'h8000, NOP, 1, 64'h8004, BEQ_M4);
    @(posedge clk); #1;
    @(negedge clk);
    stall = 1;
    idle_iq();
    #1;
    check("redir_stall.redir_vld", redirect_vld, 1);
    check("redir_stall.redir_pc", redirect_pc, 64'h8000);
    @(posedge clk); #1;
    check("redir_stall.held_vld1", f0_vld1, 1);
    check("redir_stall.held_pc1", f0_pc1, 64'h8004);
    check("redir_stall.taken", f0_pred_taken, 1);
    check("redir_stall.run_redir", redirect_vld, 0);
    check("redir_stall.stall_iq", stall_iq, 1);

    // Asynchronous reset mid-cycle with a held valid pair.
    #2;
    rst_n = 0;
    #1;
    check("arst.vld0", f0_vld0, 0);
    check("arst.vld1", f0_vld1, 0);
    check("arst.redir_vld", redirect_vld, 0);
    check("arst.stall_iq", stall_iq, 0);
    check("arst.pc0", f0_pc0, 0);
    @(negedge clk);
    stall = 0;
    rst_n = 1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch0_predecode.md
Name: fetch0_predecode

Overview:
- First fetch stage, directly downstream of the instruction queue. Takes the queue's two-instruction head pair, pre-decodes both slots for control flow and registers the pair toward decode.
- Detects JAL and backward conditional branches (static backward-taken prediction) and issues a frontend redirect plus queue flush.
- Generates the stall that holds the queue's read pointer.

Parameters:
- PC_WIDTH, 64, width of all PC and target fields.
- INST_WIDTH, 32, instruction width (fixed RV32 encoding; other values unsupported).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iq0_vld_i  in  1  head slot valid from queue.
- iq0_pc_i  in  64  head slot PC.
- iq0_inst_i  in  32  head slot instruction.
- iq1_vld_i  in  1  second slot valid.
- iq1_pc_i  in  64  second slot PC.
- iq1_inst_i  in  32  second slot instruction.
- stall_iq_o  out  1  hold queue read pointer (queue's stall input).
- flush_iq_o  out  1  invalidate all queue entries (predicted redirect).
- redirect_vld_o  out  1  one-cycle pulse: refetch from redirect_pc_o.
- redirect_pc_o  out  64  predicted target.
- f0_vld0_o  out  1  slot0 valid to decode.
- f0_pc0_o  out  64  slot0 PC.
- f0_inst0_o  out  32  slot0 instruction.
- f0_vld1_o  out  1  slot1 valid to decode.
- f0_pc1_o  out  64  slot1 PC.
- f0_inst1_o  out  32  slot1 instruction.
- f0_pred_taken_o  out  1  registered pair contains a predicted-taken CTI (last valid slot).
- stall_i  in  1  decode cannot accept this cycle.
- flush_i  in  1  backend squash (mispredict/exception).

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). Reset clears state to RUN and forces f0_vld0_o, f0_vld1_o, f0_pred_taken_o, redirect_vld_o, flush_iq_o and stall_iq_o to 0. PC, inst and redirect_pc_o fields reset to 0.
- Output register: out_vld covers the pair.
  - accept = state==RUN && iq0_vld_i && iq1_vld_i && !stall_iq_o && !flush_i. This matches exactly the queue's own dequeue condition.
  - stall_iq_o = (out_vld && stall_i) || state==REDIR.
  - Latency: a pair accepted in cycle N appears on the f0_* outputs in cycle N+1.
  - While out_vld && stall_i, all f0_* outputs are held stable.
  - If out_vld && !stall_i && !accept, out_vld clears.
- Pre-decode, per slot, combinational on iq inputs:
  - JAL: opcode[6:0]==7'b1101111. immJ = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Branch: opcode==7'b1100011. immB = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}). Predicted taken iff inst[31]==1.
  - JALR is never predicted.
  - Target = slot pc + imm, computed modulo 2^64.
- Slot priority:
  - If slot0 is predicted taken: slot1 is killed (f0_vld1_o=0) and the target uses slot0.
  - Else if slot1 is predicted taken: the target uses slot1.
  - f0_pred_taken_o is set on any taken prediction.
- FSM:
  - RUN: on accept with a taken prediction, latch redirect_pc_o and go to REDIR.
  - REDIR (exactly 1 cycle): redirect_vld_o = flush_iq_o = !flush_i; stall_iq_o=1, so no wrong-path pair is consumed. Next state is RUN.
  - Outside REDIR, redirect_vld_o and flush_iq_o are 0.
- flush_i priority (highest):
  - Clears out_vld and f0_pred_taken_o next cycle and forces RUN.
  - Suppresses redirect_vld_o and flush_iq_o in the same cycle.
  - A pair presented during flush_i is not accepted.
- Simultaneous accept with stall_i while out_vld=1 cannot occur, because stall_iq_o blocks it.
- REDIR followed by stall_i: the registered pair stays held. Redirect is not delayed by downstream stall.
- Partial pair (only iq0_vld_i=1): not accepted; waits, consistent with the queue's pair-dequeue rule.

Test Plan:
- Reset mid-run: out_vld=1, rst_n low asynchronously -> all valids, redirect_vld_o and stall_iq_o read 0 before the next clk edge.
- Straight-line pair: pc0=0x1000 inst=0x00000013, pc1=0x1004 inst=0x00000013, stall_i=0 -> next cycle f0_vld0_o=f0_vld1_o=1, pcs 0x1000/0x1004, f0_pred_taken_o=0, redirect_vld_o=0.
- JAL in slot0: iq0_inst_i=0x0100006F (jal x0,+16) at pc0=0x2000 -> f0_vld1_o=0. Following cycle: redirect_vld_o=1, flush_iq_o=1, redirect_pc_o=0x2010, stall_iq_o=1, then back to RUN.
- Backward branch in slot1: iq1_inst_i=0xFE000EE3 (beq x0,x0,-4) at pc1=0x3004 -> f0_vld1_o=1, redirect_pc_o=0x3000. A forward branch (0x00000463) at the same slot produces no redirect.
- Downstream stall: stall_i=1 for 3 cycles with out_vld=1 -> stall_iq_o=1, f0_* outputs unchanged for all 3 cycles. Drop stall_i -> next pair accepted in that same cycle.
- flush_i during REDIR: flush_i=1 in the REDIR cycle -> redirect_vld_o=0, flush_iq_o=0, out_vld=0 next cycle, state RUN.
